// File: rtl/bcd_preset_entry.sv
// Push-button BCD preset editor: debounce, edge detect, auto-repeat and edit FSM driving a one-clock counter load strobe.
// Blinking of the edited value is built only when `PRESET_BLINK_EN is defined; otherwise blink_o is tied low.
module bcd_preset_entry #(
    parameter int DEBOUNCE_LEN = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int TIMEOUT      = 5000
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       tick_1kHz_i,
    input  logic [3:0] PUSH_BUTTON_N_I,
    input  logic [7:0] current_value_i,
    output logic [7:0] preset_value_o,
    output logic       preset_load_o,
    output logic       edit_active_o,
    output logic       edit_digit_o,
    output logic [7:0] working_value_o,
    output logic       blink_o
);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EDIT_UNITS, EDIT_TENS, COMMIT} state_t;

    state_t                         state_q;
    logic [3:0][DEBOUNCE_LEN-1:0]   shift_q;
    logic [3:0]                     status_q, status_dly_q, edge_ev;
    logic [1:0][RW-1:0]             rpt_q, rpt_d;
    logic [1:0]                     rpt_ev;
    logic [TW-1:0]                  tmo_q;
    logic [7:0]                     preset_q, working_q;
    logic                           load_q, active_q, digit_q;
    logic                           in_edit, inc_raw, dec_raw;
    logic                           ev_commit, ev_sel, ev_inc, ev_dec, accepted;
    logic [3:0]                     sel_nib, new_nib;

    function automatic logic [3:0] bcd_step(input logic [3:0] n, input logic up);
        if (up)
            return (n >= 4'd9) ? 4'd0 : n + 4'd1;
        else
            return (n == 4'd0 || n > 4'd9) ? 4'd9 : n - 4'd1;
    endfunction

    // Status is a registered OR of the tick-sampled history, so it rises one clock after the first sampled press.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            shift_q      <= '0;
            status_q     <= '0;
            status_dly_q <= '0;
            rpt_q        <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tick_1kHz_i)
                    shift_q[i] <= {shift_q[i][DEBOUNCE_LEN-2:0], ~PUSH_BUTTON_N_I[i]};
                status_q[i] <= |shift_q[i];
            end
            status_dly_q <= status_q;
            rpt_q        <= rpt_d;
        end
    end

    assign edge_ev = status_q & ~status_dly_q;
    assign in_edit = (state_q == EDIT_UNITS) || (state_q == EDIT_TENS);

    always_comb begin
        rpt_d  = rpt_q;
        rpt_ev = '0;
        for (int j = 0; j < 2; j++) begin
            if (!in_edit || !status_q[j+1]) begin
                rpt_d[j] = '0;
            end else if (tick_1kHz_i) begin
                if (rpt_q[j] == RW'(REPEAT_DELAY - 1)) begin
                    rpt_ev[j] = 1'b1;
                    rpt_d[j]  = RW'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    rpt_d[j] = rpt_q[j] + 1'b1;
                end
            end
        end
    end

    // PB0 beats PB3 beats inc/dec; simultaneous inc and dec cancel each other.
    assign inc_raw   = edge_ev[1] | rpt_ev[0];
    assign dec_raw   = edge_ev[2] | rpt_ev[1];
    assign ev_commit = edge_ev[0];
    assign ev_sel    = edge_ev[3] & ~edge_ev[0];
    assign ev_inc    = inc_raw & ~dec_raw & ~edge_ev[0] & ~edge_ev[3];
    assign ev_dec    = dec_raw & ~inc_raw & ~edge_ev[0] & ~edge_ev[3];
    assign accepted  = ev_commit | ev_sel | ev_inc | ev_dec;
    assign sel_nib   = (state_q == EDIT_TENS) ? working_q[7:4] : working_q[3:0];
    assign new_nib   = bcd_step(sel_nib, ev_inc);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            preset_q  <= 8'h00;
            working_q <= 8'h00;
            load_q    <= 1'b0;
            active_q  <= 1'b0;
            digit_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev_commit) begin
                        working_q <= current_value_i;
                        state_q   <= EDIT_UNITS;
                        tmo_q     <= '0;
                        active_q  <= 1'b1;
                        digit_q   <= 1'b0;
                    end
                end
                EDIT_UNITS, EDIT_TENS: begin
                    if (accepted) begin
                        tmo_q <= '0;
                    end else if (tick_1kHz_i) begin
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            tmo_q    <= '0;
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                            digit_q  <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    if (ev_commit) begin
                        state_q  <= COMMIT;
                        active_q <= 1'b0;
                        digit_q  <= 1'b0;
                    end else if (ev_sel) begin
                        state_q <= (state_q == EDIT_UNITS) ? EDIT_TENS : EDIT_UNITS;
                        digit_q <= (state_q == EDIT_UNITS);
                    end else if (ev_inc || ev_dec) begin
                        if (state_q == EDIT_TENS)
                            working_q[7:4] <= new_nib;
                        else
                            working_q[3:0] <= new_nib;
                    end
                end
                COMMIT: begin
                    preset_q <= working_q;
                    load_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign preset_value_o  = preset_q;
    assign preset_load_o   = load_q;
    assign edit_active_o   = active_q;
    assign edit_digit_o    = digit_q;
    assign working_value_o = working_q;

`ifdef PRESET_BLINK_EN
    logic [7:0] blink_cnt_q;
    logic       blink_q;

    // PB3 restarts the phase so the newly selected digit starts visible.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (!in_edit || ev_sel) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (tick_1kHz_i) begin
            if (blink_cnt_q == 8'd249) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_o = blink_q & active_q;
`else
    assign blink_o = 1'b0;
`endif
endmodule
